// File: rtl/seven_segment_display_driver.sv
// seven_segment_display_driver
//   Converts a binary register value to BCD with a sequential double-dabble
//   engine. It latches the finished digits and time-multiplexes them onto a
//   shared seven-segment bus.
//
// Ports:
//   clock          in   system clock, rising edge
//   isReset        in   synchronous active-low reset
//   register1Value in   [REGISTER_WIDTH-1:0] binary value to display
//   segments       out  [6:0] {g,f,e,d,c,b,a}, active high, registered
//   digitEnable    out  [NUM_DIGITS-1:0] one-hot digit select (bit 0 = LSD), registered
//   bcdValid       out  set once a conversion has completed since reset
//   busy           out  high while a conversion is in progress
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   When defined, leading zero digits above digit 0 are blanked (segments 00).
//   When undefined, every digit always shows its encoded value.

module seven_segment_display_driver #(
  parameter int unsigned REGISTER_WIDTH = 8,
  parameter int unsigned NUM_DIGITS     = 3,
  parameter int unsigned SCAN_DIVIDER   = 1000
) (
  input  logic                      clock,
  input  logic                      isReset,
  input  logic [REGISTER_WIDTH-1:0] register1Value,
  output logic [6:0]                segments,
  output logic [NUM_DIGITS-1:0]     digitEnable,
  output logic                      bcdValid,
  output logic                      busy
);

  localparam int unsigned BW = 4 * NUM_DIGITS;
  localparam int unsigned CW = $clog2(REGISTER_WIDTH + 1);
  localparam int unsigned SW = $clog2(SCAN_DIVIDER);
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

  state_e                    state_q, state_d;
  logic [REGISTER_WIDTH-1:0] snap_q, snap_d;
  logic [REGISTER_WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]             bcd_q, bcd_d;
  logic [BW-1:0]             adj;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      force_q, force_d;
  logic [BW-1:0]             digits_q, digits_d;
  logic                      valid_q, valid_d;
  logic                      busy_q, busy_d;
  logic [SW-1:0]             scan_q, scan_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [NUM_DIGITS-1:0]     en_q, en_d;
  logic [6:0]                seg_q, seg_d;
  logic [3:0]                nib;
  logic                      start;
  logic                      scan_wrap;
`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0]     blank_q, blank_d;
  logic                      lead_nz;
`endif

  // A new conversion starts after reset or whenever the input differs from
  // the last captured value; changes made while busy are picked up here later.
  assign start = force_q || (register1Value != snap_q);

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (!isReset) begin
      state_q  <= IDLE;
      snap_q   <= '0;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      force_q  <= 1'b1;
      digits_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      scan_q   <= '0;
      idx_q    <= '0;
      en_q     <= '0;
      seg_q    <= '0;
`ifdef LEADING_ZERO_BLANK_EN
      blank_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      force_q  <= force_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      scan_q   <= scan_d;
      idx_q    <= idx_d;
      en_q     <= en_d;
      seg_q    <= seg_d;
`ifdef LEADING_ZERO_BLANK_EN
      blank_q  <= blank_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (cnt_q == CW'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath / output logic
  always_comb begin
    snap_d   = snap_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    force_d  = force_q;
    digits_d = digits_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
`ifdef LEADING_ZERO_BLANK_EN
    blank_d  = blank_q;
    lead_nz  = 1'b0;
`endif

    // Double-dabble add-3 correction for every nibble
    adj = bcd_q;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          snap_d  = register1Value;
          bin_d   = register1Value;
          bcd_d   = '0;
          force_d = 1'b0;
        end
      end
      LOAD: begin
        busy_d = 1'b1;
        cnt_d  = CW'(REGISTER_WIDTH);
      end
      SHIFT: begin
        {bcd_d, bin_d} = {adj, bin_q} << 1;
        cnt_d          = cnt_q - 1'b1;
      end
      DONE: begin
        digits_d = bcd_q;
        valid_d  = 1'b1;
        busy_d   = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        // Walk down from the top digit; blank until the first nonzero one.
        blank_d = '0;
        for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
          if (bcd_q[4*i +: 4] != 4'd0) lead_nz = 1'b1;
          blank_d[i] = ~lead_nz;
        end
`endif
      end
      default: ;
    endcase
  end

  // Scan: digit index advances on each divider wrap. Enable and segments are
  // registered together from the same index so they change on the same edge.
  always_comb begin
    scan_wrap = (scan_q == SW'(SCAN_DIVIDER - 1));
    scan_d    = scan_wrap ? '0 : scan_q + 1'b1;
    idx_d     = idx_q;
    if (scan_wrap) idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;

    en_d        = '0;
    en_d[idx_q] = 1'b1;

    nib = digits_q[{idx_q, 2'b00} +: 4];
    unique case (nib)
      4'd0:    seg_d = 7'h3F;
      4'd1:    seg_d = 7'h06;
      4'd2:    seg_d = 7'h5B;
      4'd3:    seg_d = 7'h4F;
      4'd4:    seg_d = 7'h66;
      4'd5:    seg_d = 7'h6D;
      4'd6:    seg_d = 7'h7D;
      4'd7:    seg_d = 7'h07;
      4'd8:    seg_d = 7'h7F;
      4'd9:    seg_d = 7'h6F;
      default: seg_d = 7'h00;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    if (blank_q[idx_q]) seg_d = 7'h00;
`endif
  end

  assign segments    = seg_q;
  assign digitEnable = en_q;
  assign bcdValid    = valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_seven_segment_display_driver.sv
module tb_seven_segment_display_driver;

  localparam int unsigned RW  = 8;
  localparam int unsigned ND  = 3;
  localparam int unsigned DIV = 4;

  logic          clock = 1'b0;
  logic          isReset;
  logic [RW-1:0] register1Value;
  logic [6:0]    segments;
  logic [ND-1:0] digitEnable;
  logic          bcdValid;
  logic          busy;

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;
  int unsigned exp_q[$];

  seven_segment_display_driver #(
    .REGISTER_WIDTH(RW),
    .NUM_DIGITS    (ND),
    .SCAN_DIVIDER  (DIV)
  ) dut (
    .clock         (clock),
    .isReset       (isReset),
    .register1Value(register1Value),
    .segments      (segments),
    .digitEnable   (digitEnable),
    .bcdValid      (bcdValid),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [6:0] enc(input int unsigned d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Expected {digit2, digit1, digit0} segment patterns for a value
  function automatic logic [20:0] disp_model(input int unsigned v);
    int unsigned d0, d1, d2;
    logic [6:0] s0, s1, s2;
    d0 = v % 10;
    d1 = (v / 10) % 10;
    d2 = (v / 100) % 10;
    s0 = enc(d0);
    s1 = enc(d1);
    s2 = enc(d2);
`ifdef LEADING_ZERO_BLANK_EN
    if (d2 == 0) s2 = 7'h00;
    if (d2 == 0 && d1 == 0) s1 = 7'h00;
`endif
    return {s2, s1, s0};
  endfunction

  function automatic logic [6:0] seg_of(input logic [20:0] m, input logic [ND-1:0] en);
    case (en)
      3'b001:  return m[6:0];
      3'b010:  return m[13:7];
      3'b100:  return m[20:14];
      default: return 7'h7F;
    endcase
  endfunction

  // Wait for a busy high->low transition (end of a conversion), bounded
  task automatic wait_done(output bit ok);
    bit seen;
    int unsigned c;
    seen = 0;
    ok   = 0;
    c    = 0;
    while (!ok && c < 60) begin
      tick();
      c++;
      if (busy) seen = 1;
      else if (seen) ok = 1;
    end
  endtask

  // Collect the segment pattern shown for each digit position, bounded
  task automatic read_display(output logic [20:0] disp, output bit ok);
    logic [2:0] seen;
    int unsigned c;
    seen = '0;
    disp = '0;
    c    = 0;
    while (seen != 3'b111 && c < 40) begin
      tick();
      c++;
      case (digitEnable)
        3'b001: if (!seen[0]) begin disp[6:0]   = segments; seen[0] = 1'b1; end
        3'b010: if (!seen[1]) begin disp[13:7]  = segments; seen[1] = 1'b1; end
        3'b100: if (!seen[2]) begin disp[20:14] = segments; seen[2] = 1'b1; end
        default: ;
      endcase
    end
    ok = (seen == 3'b111);
  endtask

  task automatic test_reset();
    isReset        = 1'b0;
    register1Value = 8'hFF;
    tick();
    tick();
    tests_run++;
    if (segments !== 7'h00) begin
      tests_failed++; $display("FAIL reset_segments: got %h expected 00", segments);
    end
    tests_run++;
    if (digitEnable !== 3'b000) begin
      tests_failed++; $display("FAIL reset_digitEnable: got %b expected 000", digitEnable);
    end
    tests_run++;
    if (bcdValid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_bcdValid: got %b expected 0", bcdValid);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_convert_ff();
    logic [20:0] got;
    bit ok;
    int unsigned v;
    isReset = 1'b1;
    exp_q.push_back(255);
    tick();  // capture edge
    for (int k = 1; k <= 9; k++) begin
      tick();
      tests_run++;
      if ({busy, bcdValid} !== 2'b10) begin
        tests_failed++;
        $display("FAIL ff_busy_k%0d: got busy/valid %b expected 10", k, {busy, bcdValid});
      end
    end
    tick();
    tests_run++;
    if ({busy, bcdValid} !== 2'b01) begin
      tests_failed++; $display("FAIL ff_done_k10: got busy/valid %b expected 01", {busy, bcdValid});
    end
    v = exp_q.pop_front();
    read_display(got, ok);
    tests_run++;
    if (!ok || got !== disp_model(v)) begin
      tests_failed++; $display("FAIL ff_display: got %h expected %h", got, disp_model(v));
    end
  endtask

  task automatic test_change_during_shift();
    logic [20:0] got;
    bit ok;
    int unsigned v;
    register1Value = 8'd12;
    exp_q.push_back(12);
    tick();  // capture
    tick();
    tick();
    tick();  // now in SHIFT
    register1Value = 8'd200;
    exp_q.push_back(200);
    for (int n = 0; n < 2; n++) begin
      wait_done(ok);
      tests_run++;
      if (!ok) begin
        tests_failed++; $display("FAIL chg_done%0d: got timeout expected busy fall", n);
      end
      v = exp_q.pop_front();
      read_display(got, ok);
      tests_run++;
      if (!ok || got !== disp_model(v)) begin
        tests_failed++; $display("FAIL chg_display%0d: got %h expected %h", n, got, disp_model(v));
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [20:0] got;
    bit ok;
    int unsigned v;
    register1Value = 8'd99;
    tick();  // capture
    for (int k = 0; k < 4; k++) tick();
    isReset = 1'b0;
    tick();
    tests_run++;
    if ({segments, digitEnable, bcdValid, busy} !== 12'h000) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got seg=%h en=%b valid=%b busy=%b expected all zero",
               segments, digitEnable, bcdValid, busy);
    end
    isReset = 1'b1;
    exp_q.push_back(99);
    tick();  // forced capture
    for (int k = 1; k <= 9; k++) tick();
    tests_run++;
    if ({busy, bcdValid} !== 2'b10) begin
      tests_failed++; $display("FAIL midreset_k9: got busy/valid %b expected 10", {busy, bcdValid});
    end
    tick();
    tests_run++;
    if ({busy, bcdValid} !== 2'b01) begin
      tests_failed++; $display("FAIL midreset_k10: got busy/valid %b expected 01", {busy, bcdValid});
    end
    v = exp_q.pop_front();
    read_display(got, ok);
    tests_run++;
    if (!ok || got !== disp_model(v)) begin
      tests_failed++; $display("FAIL midreset_display: got %h expected %h", got, disp_model(v));
    end
  endtask

  task automatic test_zero_force();
    logic [20:0] got;
    bit ok;
    int unsigned v;
    register1Value = 8'd0;
    isReset = 1'b0;
    tick();
    tick();
    isReset = 1'b1;
    exp_q.push_back(0);
    wait_done(ok);
    tests_run++;
    if (!ok || bcdValid !== 1'b1) begin
      tests_failed++; $display("FAIL zero_forced: got done=%b valid=%b expected 1 1", ok, bcdValid);
    end
    v = exp_q.pop_front();
    read_display(got, ok);
    tests_run++;
    if (!ok || got !== disp_model(v)) begin
      tests_failed++; $display("FAIL zero_display: got %h expected %h", got, disp_model(v));
    end
  endtask

  task automatic test_scan();
    logic [20:0] got, m;
    logic [ND-1:0] prev, cur, nxt;
    bit ok;
    int unsigned v, c;
    register1Value = 8'd37;
    exp_q.push_back(37);
    wait_done(ok);
    v = exp_q.pop_front();
    m = disp_model(v);
    read_display(got, ok);
    tests_run++;
    if (!ok || got !== m) begin
      tests_failed++; $display("FAIL scan_display: got %h expected %h", got, m);
    end
    prev = digitEnable;
    c = 0;
    while (digitEnable === prev && c < 2 * DIV) begin
      tick();
      c++;
    end
    tests_run++;
    if (digitEnable === prev) begin
      tests_failed++; $display("FAIL scan_change: got no change expected change within %0d", 2 * DIV);
    end
    cur = digitEnable;
    for (int s = 0; s < 4; s++) begin
      for (int h = 1; h < DIV; h++) begin
        tick();
        tests_run++;
        if ({digitEnable, segments} !== {cur, seg_of(m, cur)}) begin
          tests_failed++;
          $display("FAIL scan_hold%0d_%0d: got en=%b seg=%h expected en=%b seg=%h",
                   s, h, digitEnable, segments, cur, seg_of(m, cur));
        end
      end
      tick();
      nxt = {cur[1:0], cur[2]};
      tests_run++;
      if ({digitEnable, segments} !== {nxt, seg_of(m, nxt)}) begin
        tests_failed++;
        $display("FAIL scan_step%0d: got en=%b seg=%h expected en=%b seg=%h",
                 s, digitEnable, segments, nxt, seg_of(m, nxt));
      end
      cur = nxt;
    end
  endtask

  task automatic test_blank();
    logic [20:0] got;
    logic [13:0] upper_exp;
    bit ok;
    int unsigned v;
`ifdef LEADING_ZERO_BLANK_EN
    upper_exp = 14'h0000;
`else
    upper_exp = {7'h3F, 7'h3F};
`endif
    register1Value = 8'd7;
    exp_q.push_back(7);
    wait_done(ok);
    v = exp_q.pop_front();
    read_display(got, ok);
    tests_run++;
    if (!ok || got !== disp_model(v)) begin
      tests_failed++; $display("FAIL blank_display: got %h expected %h", got, disp_model(v));
    end
    tests_run++;
    if (got[20:7] !== upper_exp || got[6:0] !== 7'h07) begin
      tests_failed++;
      $display("FAIL blank_upper: got %h/%h expected %h/07", got[20:7], got[6:0], upper_exp);
    end
  endtask

  task automatic test_steady();
    int unsigned busy_cnt, inval_cnt;
    busy_cnt  = 0;
    inval_cnt = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (busy !== 1'b0) busy_cnt++;
      if (bcdValid !== 1'b1) inval_cnt++;
    end
    tests_run++;
    if (busy_cnt != 0) begin
      tests_failed++; $display("FAIL steady_busy: got %0d busy cycles expected 0", busy_cnt);
    end
    tests_run++;
    if (inval_cnt != 0) begin
      tests_failed++; $display("FAIL steady_valid: got %0d invalid cycles expected 0", inval_cnt);
    end
  endtask

  initial begin
    isReset        = 1'b0;
    register1Value = 8'hFF;
    test_reset();
    test_convert_ff();
    test_change_during_shift();
    test_reset_mid_shift();
    test_zero_force();
    test_scan();
    test_blank();
    test_steady();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seven_segment_display_driver.md
Name: seven_segment_display_driver

Overview:
- Downstream consumer of the CPU's `register1Value` output.
- Converts the binary register value to BCD with a sequential double-dabble engine, latches the digits, and time-multiplexes them onto a common seven-segment bus.
- Sits between the CPU and the board-level display pins.

Parameters:
- REGISTER_WIDTH, 8, width of `register1Value`; must match the CPU's register width.
- NUM_DIGITS, 3, number of display digits; 10^NUM_DIGITS must exceed 2^REGISTER_WIDTH.
- SCAN_DIVIDER, 1000, clock cycles each digit stays enabled before the scan advances; must be ≥ 2.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- isReset  input  1  synchronous, active-low reset. Low at a rising edge resets the block.
- register1Value  input  REGISTER_WIDTH  binary value to display.
- segments  output  7  {g,f,e,d,c,b,a}, active high, registered.
- digitEnable  output  NUM_DIGITS  one-hot digit select; bit 0 is the least significant digit; registered.
- bcdValid  output  1  high once at least one conversion has completed since reset.
- busy  output  1  high while a conversion is in progress.

Behaviour:
- Reset (isReset low at an edge):
  - state=IDLE; segments=0, digitEnable=0, bcdValid=0, busy=0.
  - Latched digits = 0, snapshot = 0, scan counter = 0, digit index = 0.
  - forceConvert flag = 1.
- Reset asserted mid-conversion aborts it immediately; the partial result is discarded.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - If forceConvert=1 or register1Value != snapshot: capture register1Value into snapshot and a shift register, clear the BCD accumulator, clear forceConvert, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD: busy=1, load the iteration counter with REGISTER_WIDTH, go to SHIFT.
- SHIFT: one iteration per cycle.
  - Every BCD nibble ≥ 5 gets +3.
  - Then shift {BCD, binary} left by 1 and decrement the counter.
  - When the counter reaches 1 at this edge, go to DONE.
- DONE:
  - Copy the BCD accumulator to the latched display digits.
  - bcdValid=1, busy=0, go to IDLE.
- Latency: from the capture edge in IDLE to the latched digits updating is REGISTER_WIDTH+2 edges (10 for the default).
- Input changes during LOAD/SHIFT/DONE are ignored. The next IDLE cycle compares against the snapshot and restarts if they differ; the last value is never lost.
- The display reads only the latched digits, so a conversion in progress never produces tearing.
- Scan:
  - The scan counter runs 0..SCAN_DIVIDER-1 continuously from the first post-reset cycle.
  - On wrap, the digit index advances; after NUM_DIGITS-1 it returns to 0.
  - digitEnable = one-hot(index), registered.
  - segments = encode(latched digit[index]), registered in the same cycle, so both update together.
- Encoding, digits 0..9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F (hex). Nibbles > 9 cannot occur; if one does, output 00.
- Before the first DONE, the latched digits are 0, so the display shows "000".

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - When the display digits are latched, each digit above the most significant nonzero digit gets a blank flag; its segments output is 00.
  - Digit 0 is never blanked, so a value of 0 displays "0".
  - digitEnable still scans all digits.
- Undefined: no blanking logic exists; all digits always show their encoded value, including leading zeros.

Test Plan:
- Reset low 2 cycles, release, register1Value=8'hFF → busy high on the edges after capture; 10 edges after capture, bcdValid=1 and digits={2,5,5}. Scan (SCAN_DIVIDER=4) shows digitEnable 001/seg 6D, 010/6D, 100/5B.
- register1Value changes 8'd12 → 8'd200 during SHIFT → the first DONE latches {0,1,2}. The following conversion latches {2,0,0} with no input change needed after DONE.
- Reset driven low mid-SHIFT → next edge: segments=0, digitEnable=0, bcdValid=0, busy=0. After release, a forced conversion of the current input completes in 10 edges.
- SCAN_DIVIDER=4, steady value 8'd37 → digitEnable changes every 4 cycles, sequence 001→010→100→001. The segments pattern changes on exactly the same edge.
- register1Value=8'd7 → with LEADING_ZERO_BLANK_EN defined: digits 2 and 1 output 00, digit 0 outputs 07. Without the macro: digits 2 and 1 output 3F.
- register1Value held constant after the first conversion → no further busy pulses for 100 cycles; bcdValid stays 1.
